// File: rtl/ctrl_step_sequencer_pkg.sv
// Shared constants and state type for the hardwired control-step sequencer.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NOP = 5'b00000;
    localparam logic [4:0] ALU_ADD = 5'b00011;

    localparam logic [3:0] STEP_IDLE = 4'd0;
    localparam logic [3:0] STEP_T0   = 4'd1;
    localparam logic [3:0] STEP_T1   = 4'd2;
    localparam logic [3:0] STEP_T2   = 4'd3;
    localparam logic [3:0] STEP_T3   = 4'd4;
    localparam logic [3:0] STEP_T4   = 4'd5;
    localparam logic [3:0] STEP_T5   = 4'd6;
    localparam logic [3:0] STEP_T6   = 4'd7;
    localparam logic [3:0] STEP_T7   = 4'd8;
    localparam logic [3:0] STEP_HALT = 4'd15;

    // State codes equal the externally visible step numbers.
    typedef enum logic [3:0] {
        ST_IDLE = STEP_IDLE,
        ST_T0   = STEP_T0,
        ST_T1   = STEP_T1,
        ST_T2   = STEP_T2,
        ST_T3   = STEP_T3,
        ST_T4   = STEP_T4,
        ST_T5   = STEP_T5,
        ST_T6   = STEP_T6,
        ST_T7   = STEP_T7,
        ST_HALT = STEP_HALT
    } state_t;

    function automatic logic op_supported(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/ctrl_step_sequencer_if.sv
// Control bundle between the step sequencer (master) and the CPU datapath (slave).
interface ctrl_step_sequencer_if;

    logic       Run;
    logic       Stop;
    logic [4:0] IR_op;
    logic       Mem_ready;

    logic PCout, IncPC, PCin, MARin, Read, Write, MDRin, MDRout, IRin;
    logic Yin, Zin, Zlowout, Cout, GRA, GRB, Rin, Rout, BAout;

    logic [4:0] operation;
    logic [3:0] step;
    logic       Busy;
    logic       Illegal;
    logic       Mem_err;

    modport master (
        input  Run, Stop, IR_op, Mem_ready,
        output PCout, IncPC, PCin, MARin, Read, Write, MDRin, MDRout, IRin,
               Yin, Zin, Zlowout, Cout, GRA, GRB, Rin, Rout, BAout,
               operation, step, Busy, Illegal, Mem_err
    );

    modport slave (
        output Run, Stop, IR_op, Mem_ready,
        input  PCout, IncPC, PCin, MARin, Read, Write, MDRin, MDRout, IRin,
               Yin, Zin, Zlowout, Cout, GRA, GRB, Rin, Rout, BAout,
               operation, step, Busy, Illegal, Mem_err
    );

endinterface

// File: rtl/ctrl_step_sequencer_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory step and flags the timeout cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // cnt holds the low cycles already seen, so the current low cycle is the
    // MEM_TIMEOUT-th one when cnt == MEM_TIMEOUT-1.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)                     cnt <= '0;
        else if (clear)                   cnt <= '0;
        else if (waiting && cnt != LAST)  cnt <= cnt + 1'b1;
    end

    assign expired = waiting && (cnt == LAST);

endmodule

// File: rtl/ctrl_step_sequencer.sv
// Hardwired T0..T7 control sequencer for fetch and ld/ldi/st, with memory
// handshake timeout, run/stop control and halt/illegal-opcode handling.
module ctrl_step_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int         MEM_TIMEOUT = 15,
    parameter logic [4:0] ADD_OP      = ALU_ADD
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    ctrl_step_sequencer_if.master bus
);

    state_t state;
    state_t end_state;
    logic   illegal_q, mem_err_q;
    logic   is_ld, is_ldi, is_st, legal;
    logic   in_mem, mem_wait, mem_expired, timer_clear;

    assign is_ld  = (bus.IR_op == OP_LD);
    assign is_ldi = (bus.IR_op == OP_LDI);
    assign is_st  = (bus.IR_op == OP_ST);
    assign legal  = op_supported(bus.IR_op);

    assign in_mem = (state == ST_T1) || (state == ST_T6 && is_ld) || (state == ST_T7 && is_st);
    assign mem_wait    = in_mem && !bus.Mem_ready;
    assign timer_clear = !in_mem;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .clear   (timer_clear),
        .waiting (mem_wait),
        .expired (mem_expired)
    );

    always_comb end_state = bus.Stop ? ST_IDLE : ST_T0;

    // mem_expired only rises in a memory step with Mem_ready low, so a
    // completing handshake always takes priority over the timeout.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else if (mem_expired) begin
            state     <= ST_HALT;
            mem_err_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: if (bus.Run && !bus.Stop) state <= ST_T0;
                ST_T0:   state <= ST_T1;
                ST_T1:   if (bus.Mem_ready) state <= ST_T2;
                ST_T2:   state <= ST_T3;
                ST_T3: begin
                    if (legal) begin
                        state <= ST_T4;
                    end else begin
                        state <= ST_HALT;
                        if (bus.IR_op != OP_HALT) illegal_q <= 1'b1;
                    end
                end
                ST_T4:   state <= ST_T5;
                ST_T5:   state <= is_ldi ? end_state : ST_T6;
                ST_T6:   if (!is_ld || bus.Mem_ready) state <= ST_T7;
                ST_T7:   if (is_ld || bus.Mem_ready) state <= end_state;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.PCout     = 1'b0;
        bus.IncPC     = 1'b0;
        bus.PCin      = 1'b0;
        bus.MARin     = 1'b0;
        bus.Read      = 1'b0;
        bus.Write     = 1'b0;
        bus.MDRin     = 1'b0;
        bus.MDRout    = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zin       = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.Cout      = 1'b0;
        bus.GRA       = 1'b0;
        bus.GRB       = 1'b0;
        bus.Rin       = 1'b0;
        bus.Rout      = 1'b0;
        bus.BAout     = 1'b0;
        bus.operation = ALU_NOP;
        case (state)
            ST_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.PCin  = 1'b1;
            end
            ST_T1: begin
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
            end
            ST_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            ST_T3: if (legal) begin
                bus.GRB   = 1'b1;
                bus.BAout = 1'b1;
                bus.Yin   = 1'b1;
            end
            ST_T4: begin
                bus.Cout      = 1'b1;
                bus.Zin       = 1'b1;
                bus.operation = ADD_OP;
            end
            ST_T5: begin
                bus.Zlowout = 1'b1;
                if (is_ldi) begin
                    bus.GRA = 1'b1;
                    bus.Rin = 1'b1;
                end else begin
                    bus.MARin = 1'b1;
                end
            end
            ST_T6: begin
                if (is_ld) begin
                    bus.Read  = 1'b1;
                    bus.MDRin = 1'b1;
                end else if (is_st) begin
                    bus.GRA   = 1'b1;
                    bus.Rout  = 1'b1;
                    bus.MDRin = 1'b1;
                end
            end
            ST_T7: begin
                if (is_ld) begin
                    bus.MDRout = 1'b1;
                    bus.GRA    = 1'b1;
                    bus.Rin    = 1'b1;
                end else if (is_st) begin
                    bus.Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.step    = state;
    assign bus.Busy    = (state != ST_IDLE) && (state != ST_HALT);
    assign bus.Illegal = illegal_q;
    assign bus.Mem_err = mem_err_q;

endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// Self-checking bench: an instruction-level model expands each instruction into
// its expected step/strobe sequence, which is compared cycle by cycle.
module tb_ctrl_step_sequencer;

    localparam int TO = 4;

    localparam int PCO = 17, INC = 16, PCI = 15, MAR = 14, RD = 13, WR = 12;
    localparam int MDRI = 11, MDRO = 10, IRI = 9, YI = 8, ZI = 7, ZLO = 6;
    localparam int CO = 5, GA = 4, GB = 3, RI = 2, RO = 1, BA = 0;

    logic Clock = 1'b0;
    logic Reset_n;

    ctrl_step_sequencer_if bus();

    ctrl_step_sequencer #(.MEM_TIMEOUT(TO), .ADD_OP(5'b00011)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [29:0] exp;
        logic        rdy;
        logic        run;
        logic        stop;
        logic [4:0]  op;
    } ent_t;

    ent_t        q[$];
    logic [29:0] obs_q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_state;
    logic        m_ill, m_merr;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected output word for a given step and opcode, straight from the step table.
    function automatic logic [29:0] mk(input int step, input logic [4:0] op);
        logic [17:0] s   = '0;
        logic [4:0]  alu = '0;
        logic        ld  = (op == 5'd0);
        logic        ldi = (op == 5'd1);
        logic        st  = (op == 5'd2);
        logic        busy = (step >= 1 && step <= 8);
        case (step)
            1: begin s[PCO] = 1; s[MAR] = 1; s[INC] = 1; s[PCI] = 1; end
            2: begin s[RD] = 1; s[MDRI] = 1; end
            3: begin s[MDRO] = 1; s[IRI] = 1; end
            4: if (ld || ldi || st) begin s[GB] = 1; s[BA] = 1; s[YI] = 1; end
            5: begin s[CO] = 1; s[ZI] = 1; alu = 5'b00011; end
            6: begin s[ZLO] = 1; if (ldi) begin s[GA] = 1; s[RI] = 1; end else s[MAR] = 1; end
            7: if (ld) begin s[RD] = 1; s[MDRI] = 1; end
               else if (st) begin s[GA] = 1; s[RO] = 1; s[MDRI] = 1; end
            8: if (ld) begin s[MDRO] = 1; s[GA] = 1; s[RI] = 1; end
               else if (st) s[WR] = 1;
            default: ;
        endcase
        return {4'(step), s, alu, busy, m_ill, m_merr};
    endfunction

    function automatic logic [29:0] obs();
        return {bus.step, bus.PCout, bus.IncPC, bus.PCin, bus.MARin, bus.Read, bus.Write,
                bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Cout,
                bus.GRA, bus.GRB, bus.Rin, bus.Rout, bus.BAout, bus.operation,
                bus.Busy, bus.Illegal, bus.Mem_err};
    endfunction

    function automatic void push(input int step, input logic [4:0] op,
                                 input logic rdy, input logic run, input logic stop);
        ent_t e;
        e.exp = mk(step, op); e.rdy = rdy; e.run = run; e.stop = stop; e.op = op;
        q.push_back(e);
    endfunction

    function automatic void push_idle(input logic run, input logic stop);
        push(0, 5'($urandom), rb(), run, stop);
        m_state = (run && !stop) ? 1 : 0;
    endfunction

    function automatic void push_halt(input int n);
        for (int i = 0; i < n; i++) push(15, 5'($urandom), rb(), rb(), rb());
    endfunction

    // One memory step: stall low cycles then ready, or TO low cycles and a fault.
    function automatic bit gen_mem(input int step, input logic [4:0] op, input int stall,
                                   input bit is_end, input logic stop_end);
        if (stall >= TO) begin
            for (int i = 0; i < TO; i++) push(step, op, 1'b0, rb(), rb());
            m_merr = 1'b1;
            return 1'b1;
        end
        for (int i = 0; i < stall; i++) push(step, op, 1'b0, rb(), rb());
        push(step, op, 1'b1, rb(), is_end ? stop_end : rb());
        return 1'b0;
    endfunction

    function automatic void gen_instr(input logic [4:0] op, input int s1, input int s2,
                                      input logic stop_end);
        logic ld  = (op == 5'd0);
        logic ldi = (op == 5'd1);
        logic st  = (op == 5'd2);
        push(1, op, rb(), rb(), rb());
        if (gen_mem(2, op, s1, 1'b0, 1'b0)) begin m_state = 15; return; end
        push(3, op, rb(), rb(), rb());
        push(4, op, rb(), rb(), rb());
        if (!(ld || ldi || st)) begin
            if (op != 5'b11011) m_ill = 1'b1;
            m_state = 15;
            return;
        end
        push(5, op, rb(), rb(), rb());
        if (ldi) begin
            push(6, op, rb(), rb(), stop_end);
        end else begin
            push(6, op, rb(), rb(), rb());
            if (ld) begin
                if (gen_mem(7, op, s2, 1'b0, 1'b0)) begin m_state = 15; return; end
                push(8, op, rb(), rb(), stop_end);
            end else begin
                push(7, op, rb(), rb(), rb());
                if (gen_mem(8, op, s2, 1'b1, stop_end)) begin m_state = 15; return; end
            end
        end
        m_state = stop_end ? 0 : 1;
    endfunction

    // Replay up to n queued cycles: sample outputs, then drive that cycle's inputs.
    task automatic run_q(input int n);
        obs_q.delete();
        for (int i = 0; i < q.size() && i < n; i++) begin
            obs_q.push_back(obs());
            bus.Mem_ready = q[i].rdy;
            bus.Run       = q[i].run;
            bus.Stop      = q[i].stop;
            bus.IR_op     = q[i].op;
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic assert_rst();
        Reset_n = 1'b0;
        #1;
    endtask

    task automatic release_rst();
        @(negedge Clock);
        Reset_n = 1'b1;
        bus.Run = 1'b0;
        bus.Stop = 1'b0;
        @(posedge Clock);
        #1;
        m_state = 0; m_ill = 1'b0; m_merr = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        bus.Run = 1'b0; bus.Stop = 1'b0; bus.IR_op = '0; bus.Mem_ready = 1'b0;
        #3;
        checks++;
        if (obs() !== 30'h0) begin
            errors++;
            $display("FAIL reset_state got %h want %h", obs(), 30'h0);
        end
        release_rst();
        push_idle(1'b0, 1'b0); push_idle(1'b0, 1'b1); push_idle(1'b0, 1'b0);
        run_q(1000);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== q[i].exp) begin
                errors++;
                $display("FAIL idle cyc%0d got %h want %h", i, obs_q[i], q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_ld();
        push_idle(1'b1, 1'b0);
        gen_instr(5'b00000, 0, 0, 1'b0);
        gen_instr(5'b00000, 0, 0, 1'b1);
        push_idle(1'b0, 1'b0);
        run_q(1000);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== q[i].exp) begin
                errors++;
                $display("FAIL ld cyc%0d got %h want %h", i, obs_q[i], q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_ldi();
        push_idle(1'b1, 1'b0);
        gen_instr(5'b00001, 0, 0, 1'b0);
        gen_instr(5'b00001, 2, 0, 1'b0);
        gen_instr(5'b00000, 1, 1, 1'b1);
        push_idle(1'b0, 1'b0);
        run_q(1000);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== q[i].exp) begin
                errors++;
                $display("FAIL ldi cyc%0d got %h want %h", i, obs_q[i], q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_st_stall();
        push_idle(1'b1, 1'b0);
        gen_instr(5'b00010, 0, 3, 1'b0);
        gen_instr(5'b00010, 1, 0, 1'b1);
        push_idle(1'b0, 1'b0);
        run_q(1000);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== q[i].exp) begin
                errors++;
                $display("FAIL st cyc%0d got %h want %h", i, obs_q[i], q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_halt_illegal();
        for (int k = 0; k < 2; k++) begin
            push_idle(1'b1, 1'b0);
            gen_instr(k == 0 ? 5'b10101 : 5'b11011, 0, 0, 1'b0);
            push_halt(3);
            run_q(1000);
            foreach (obs_q[i]) begin
                checks++;
                if (obs_q[i] !== q[i].exp) begin
                    errors++;
                    $display("FAIL halt%0d cyc%0d got %h want %h", k, i, obs_q[i], q[i].exp);
                end
            end
            q.delete();
            assert_rst();
            release_rst();
        end
    endtask

    task automatic test_timeout();
        // Ready arriving on the TO-th cycle completes; TO low cycles fault.
        push_idle(1'b1, 1'b0);
        gen_instr(5'b00000, TO - 1, 0, 1'b0);
        gen_instr(5'b00000, 0, TO - 1, 1'b0);
        gen_instr(5'b00010, 0, TO - 1, 1'b0);
        gen_instr(5'b00000, TO, 0, 1'b0);
        push_halt(2);
        run_q(1000);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== q[i].exp) begin
                errors++;
                $display("FAIL timeout cyc%0d got %h want %h", i, obs_q[i], q[i].exp);
            end
        end
        q.delete();
        assert_rst();
        checks++;
        if (obs() !== 30'h0) begin
            errors++;
            $display("FAIL async_rst_halt got %h want %h", obs(), 30'h0);
        end
        release_rst();
        push_idle(1'b1, 1'b0);
        gen_instr(5'b00010, 0, TO + 1, 1'b0);
        push_halt(1);
        push(15, 5'b00010, 1'b1, 1'b1, 1'b0);
        run_q(1000);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== q[i].exp) begin
                errors++;
                $display("FAIL st_timeout cyc%0d got %h want %h", i, obs_q[i], q[i].exp);
            end
        end
        q.delete();
        assert_rst();
        release_rst();
        // Reset mid-instruction, without waiting for an edge.
        push_idle(1'b1, 1'b0);
        gen_instr(5'b00010, 1, 2, 1'b0);
        run_q(7);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== q[i].exp) begin
                errors++;
                $display("FAIL mid_rst cyc%0d got %h want %h", i, obs_q[i], q[i].exp);
            end
        end
        q.delete();
        assert_rst();
        checks++;
        if (obs() !== 30'h0) begin
            errors++;
            $display("FAIL async_rst_mid got %h want %h", obs(), 30'h0);
        end
        release_rst();
    endtask

    task automatic test_stop();
        push_idle(1'b1, 1'b1);
        push_idle(1'b1, 1'b1);
        push_idle(1'b1, 1'b0);
        gen_instr(5'b00000, 0, 0, 1'b1);
        push_idle(1'b0, 1'b0);
        push_idle(1'b1, 1'b0);
        gen_instr(5'b00001, 0, 0, 1'b1);
        push_idle(1'b0, 1'b0);
        run_q(1000);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== q[i].exp) begin
                errors++;
                $display("FAIL stop cyc%0d got %h want %h", i, obs_q[i], q[i].exp);
            end
        end
        q.delete();
    endtask

    task automatic test_random();
        logic [4:0] op;
        int         r, s1, s2;
        for (int n = 0; n < 60; n++) begin
            if (m_state == 0) begin
                for (int k = $urandom_range(0, 2); k > 0; k--) push_idle(1'b0, rb());
                push_idle(1'b1, 1'b0);
            end
            r = $urandom_range(0, 9);
            if (r < 3)       op = 5'b00000;
            else if (r < 6)  op = 5'b00010;
            else if (r < 8)  op = 5'b00001;
            else if (r == 8) op = 5'b11011;
            else begin
                op = 5'($urandom);
                while (op == 5'd0 || op == 5'd1 || op == 5'd2 || op == 5'b11011) op = 5'($urandom);
            end
            s1 = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, TO - 1);
            s2 = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, TO - 1);
            gen_instr(op, s1, s2, ($urandom_range(0, 3) == 0));
            if (m_state == 15) push_halt(2);
            run_q(1000);
            foreach (obs_q[i]) begin
                checks++;
                if (obs_q[i] !== q[i].exp) begin
                    errors++;
                    $display("FAIL rand n%0d op%b cyc%0d got %h want %h", n, op, i, obs_q[i], q[i].exp);
                end
            end
            q.delete();
            if (m_state == 15) begin
                assert_rst();
                release_rst();
            end
        end
    endtask

    initial begin
        m_state = 0; m_ill = 1'b0; m_merr = 1'b0;
        test_reset();
        test_ld();
        test_ldi();
        test_st_stall();
        test_halt_illegal();
        test_timeout();
        test_stop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_step_sequencer.md
# ctrl_step_sequencer

Hardwired control-step sequencer for the simple CPU datapath. It replaces the hand-timed T0–T7 control stimulus with a clocked state machine. It drives the datapath strobes (PCout, MARin, Read, MDRin, GRA/GRB, Rin/Rout, Zin, …) for instruction fetch and the load/store family (ld, ldi, st). Compared with a fixed-length step sequence, it adds:
- a memory-ready handshake with configurable timeout;
- run/stop control;
- halt and illegal-opcode handling.

It sits beside the datapath, and its outputs connect one-to-one to the datapath control inputs.

## Interface
- MEM_TIMEOUT, 15: max consecutive cycles a memory step waits for Mem_ready before faulting (1..255).
- ADD_OP, 5'b00011: ALU operation code driven on `operation` for effective-address add.
- Clock  in  1  single system clock, all state changes on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Run  in  1  level; start fetching from IDLE.
- Stop  in  1  level; finish current instruction, then return to IDLE.
- IR_op  in  5  IR[31:27]; stable from T3 until next T2.
- Mem_ready  in  1  memory has completed the current Read/Write.
- PCout, IncPC, PCin, MARin, Read, Write, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, GRA, GRB, Rin, Rout, BAout  out  1 each  datapath strobes.
- operation  out  5  ALU op; ADD_OP in T4, else 5'b00000.
- step  out  4  IDLE=0, T0..T7=1..8, HALT=15.
- Busy  out  1  step not IDLE/HALT.
- Illegal  out  1  sticky; unsupported opcode decoded.
- Mem_err  out  1  sticky; memory timeout.

## Operation
- Opcodes: ld=5'b00000, ldi=5'b00001, st=5'b00010, halt=5'b11011. All other opcodes are illegal.
- Outputs are a Moore decode of the state register and IR_op. They are not registered. No intra-cycle delays.
- All strobes are 0 unless listed below.
- IDLE: go to T0 when Run=1 and Stop=0.
- T0: PCout, MARin, IncPC, PCin.
- T1: Read, MDRin. Stay while Mem_ready=0. Exit to T2 on the cycle Mem_ready=1.
- T2: MDRout, IRin.
- T3 (decode):
  - ld/ldi/st: GRB, BAout, Yin.
  - halt: no strobes; go to HALT.
  - illegal: no strobes; set Illegal, go to HALT.
- T4: Cout, Zin, operation=ADD_OP.
- T5:
  - ld/st: Zlowout, MARin.
  - ldi: Zlowout, GRA, Rin; instruction ends.
- T6:
  - ld: Read, MDRin; wait on Mem_ready as in T1.
  - st: GRA, Rout, MDRin.
- T7:
  - ld: MDRout, GRA, Rin; instruction ends.
  - st: Write; wait on Mem_ready; instruction ends when Mem_ready=1.
- Instruction end: go to IDLE if Stop=1 that cycle, else T0.
- HALT: all strobes 0; stays until Reset_n.
- Timeout: a wait counter clears on entry to each memory step (T1, ld-T6, st-T7) and increments per cycle with Mem_ready=0. When it reaches MEM_TIMEOUT: set Mem_err, go to HALT, deassert Read/Write.

## Timing
- Reset (async, any state, mid-instruction included): state IDLE, counter 0, Illegal=0, Mem_err=0, every output 0, step=0. Takes effect immediately, not at the next edge.
- Mem_ready tied high gives these latencies (T0 to instruction end):
  - ld: 8 cycles.
  - st: 8 cycles.
  - ldi: 6 cycles.
  - halt/illegal: 4 cycles to HALT.
- Each memory-step cycle with Mem_ready=0 adds one cycle.
- The timeout fires on the MEM_TIMEOUT-th consecutive low cycle. The next edge enters HALT.
- Mem_ready=1 on the same cycle the counter reaches MEM_TIMEOUT: completion wins, no fault.
- Mem_ready outside memory steps is ignored.
- Run is sampled only in IDLE. Stop is sampled only at instruction end.
- Run=1 and Stop=1 together in IDLE: remain in IDLE.
- Back-to-back instructions: instruction end goes straight to T0, with no idle cycle.

## Structure
- Package cpu_ctrl_pkg holds:
  - opcode constants (OP_LD, OP_LDI, OP_ST, OP_HALT);
  - step encodings (STEP_IDLE, STEP_T0..STEP_T7, STEP_HALT);
  - ALU op constants (ALU_ADD=5'b00011);
  - the state enum typedef.
- Sub-module mem_wait_timer:
  - parameter MEM_TIMEOUT;
  - inputs Clock, Reset_n, clear, waiting;
  - output expired;
  - counter width $clog2(MEM_TIMEOUT+1).

## Test plan
- ld, IR_op=00000, Mem_ready=1 -> step goes 1..8 and back to 1; Read=1 in T1 and T6; GRA&Rin=1 only in T7; operation=00011 only in T4.
- ldi, IR_op=00001 -> T5 has Zlowout&GRA&Rin=1; next cycle step=1; MARin=0 in T5.
- st, IR_op=00010, Mem_ready low 3 cycles in T7 -> Write held 4 cycles; st total 11 cycles; Write and Read never high together.
- MEM_TIMEOUT=4, Mem_ready=0 in T1 -> after 4 cycles Mem_err=1, step=15, Read=0; Reset_n low -> step=0, Mem_err=0 without a clock edge.
- IR_op=10101 -> Illegal=1, step=15 after T3; IR_op=11011 -> step=15, Illegal=0.
- Stop=1 during ld T5 -> after T7 step=0, Busy=0; Run=1 then restarts at T0.
